// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the core (m0) and a loader/debug master (m1).
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_valid,
    input  logic              m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_be,
    output logic              m0_ready,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_valid,
    input  logic              m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_be,
    output logic              m1_ready,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_be,
    input  logic [31:0]       ram_rdata,
    output logic [15:0]       conflict_cnt
);

    logic        rd_pend;
    logic        rd_owner;
    logic        last_grant;
    logic        both;
    logic        gnt0;
    logic        gnt1;
    logic        acc;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_be;

    assign both = m0_valid & m1_valid;

    // Grants are held low while reset is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
`ifdef DMEM_ARB_RR_EN
            if (both) begin
                gnt0 = last_grant;
                gnt1 = ~last_grant;
            end
`else
            if (both) begin
                gnt0 = 1'b1;
            end
`endif
            else begin
                gnt0 = m0_valid;
                gnt1 = m1_valid;
            end
        end
    end

    assign m0_ready = gnt0;
    assign m1_ready = gnt1;
    assign acc      = gnt0 | gnt1;

    assign sel_we    = gnt1 ? m1_we    : m0_we;
    assign sel_addr  = gnt1 ? m1_addr  : m0_addr;
    assign sel_wdata = gnt1 ? m1_wdata : m0_wdata;
    assign sel_be    = gnt1 ? m1_be    : m0_be;

    assign ram_en    = acc;
    assign ram_we    = acc & sel_we;
    assign ram_addr  = acc ? sel_addr[ADDR_W+1:2] : '0;
    assign ram_wdata = acc ? sel_wdata : '0;
    assign ram_be    = (acc & sel_we) ? sel_be : 4'b0000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend      <= 1'b0;
            rd_owner     <= 1'b0;
            last_grant   <= 1'b1;
            conflict_cnt <= 16'h0000;
        end else begin
            rd_pend <= acc & ~sel_we;
            if (acc & ~sel_we) begin
                rd_owner <= gnt1;
            end
            if (acc) begin
                last_grant <= gnt1;
            end
            if (both && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

    assign m0_rvalid = rd_pend & ~rd_owner;
    assign m1_rvalid = rd_pend & rd_owner;
    assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
    assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

    // Byte offset and out-of-range address bits are ignored by design.
    logic unused_ok;
`ifdef DMEM_ARB_RR_EN
    assign unused_ok = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0],
                         m1_addr[31:ADDR_W+2], m1_addr[1:0]};
`else
    assign unused_ok = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0],
                         m1_addr[31:ADDR_W+2], m1_addr[1:0], last_grant};
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random two-master traffic against a transaction-level model
// with its own memory image, plus directed reset, ordering and saturation cases.
module tb_dmem_arbiter;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              m0_valid = 1'b0, m0_we = 1'b0;
    logic [31:0]       m0_addr = '0, m0_wdata = '0;
    logic [3:0]        m0_be = '0;
    logic              m1_valid = 1'b0, m1_we = 1'b0;
    logic [31:0]       m1_addr = '0, m1_wdata = '0;
    logic [3:0]        m1_be = '0;
    logic              m0_ready, m0_rvalid, m1_ready, m1_rvalid;
    logic [31:0]       m0_rdata, m1_rdata;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_rdata;
    logic [3:0]        ram_be;
    logic [15:0]       conflict_cnt;

    dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_ready(m0_ready),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_ready(m1_ready),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_rdata(ram_rdata),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one-cycle registered read.
    logic [31:0] ram_mem [DEPTH];
    logic [31:0] ram_q = '0;
    assign ram_rdata = ram_q;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end else begin
                ram_q <= ram_mem[ram_addr];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    int          exp_last;
    int          exp_cnt;
    bit          rsp_v;
    int          rsp_own;
    logic [31:0] rsp_d;
    int          winner;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: check outputs mid-cycle against the model, then advance it.
    task automatic step();
        logic        we;
        logic [31:0] ad, wd;
        logic [3:0]  be;
        logic [9:0]  idx;
        logic [47:0] bus;
        logic [32:0] r0, r1;
        @(negedge clk);
        if (!rst) begin
            exp_last = 1;
            exp_cnt  = 0;
            rsp_v    = 0;
        end
        winner = -1;
        if (rst) begin
            if (m0_valid && m1_valid) begin
`ifdef DMEM_ARB_RR_EN
                winner = 1 - exp_last;
`else
                winner = 0;
`endif
            end else if (m0_valid) winner = 0;
            else if (m1_valid) winner = 1;
        end
        check("ready", 64'({m1_ready, m0_ready}), 64'({winner == 1, winner == 0}));
        r0 = (rsp_v && rsp_own == 0) ? {1'b1, rsp_d} : 33'h0;
        r1 = (rsp_v && rsp_own == 1) ? {1'b1, rsp_d} : 33'h0;
        check("m0_rsp", 64'({m0_rvalid, m0_rdata}), 64'(r0));
        check("m1_rsp", 64'({m1_rvalid, m1_rdata}), 64'(r1));
        we = (winner == 1) ? m1_we    : m0_we;
        ad = (winner == 1) ? m1_addr  : m0_addr;
        wd = (winner == 1) ? m1_wdata : m0_wdata;
        be = (winner == 1) ? m1_be    : m0_be;
        idx = ad[ADDR_W+1:2];
        bus = (winner < 0) ? 48'h0 : {1'b1, we, (we ? be : 4'b0000), idx, wd};
        check("ram_bus", 64'({ram_en, ram_we, ram_be, ram_addr, ram_wdata}), 64'(bus));
        check("conflict_cnt", 64'(conflict_cnt), 64'(exp_cnt));
        if (rst && m0_valid && m1_valid && exp_cnt < 65535) exp_cnt++;
        rsp_v = 0;
        if (winner >= 0) begin
            exp_last = winner;
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
            end else begin
                rsp_v   = 1;
                rsp_own = winner;
                rsp_d   = ref_mem[idx];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_req(output logic v, output logic we, output logic [31:0] a,
                            output logic [31:0] wd, output logic [3:0] be);
        v  = 1'b1;
        we = 1'($urandom_range(0, 1));
        a  = $urandom();
        a[11:2] = 10'($urandom_range(0, 15));
        wd = $urandom();
        be = 4'($urandom());
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = {16'(i) ^ 16'h5A5A, ~16'(i)};
            ref_mem[i] = ram_mem[i];
        end
        ram_mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        ram_mem[8] = 32'hAAAAAAAA; ref_mem[8] = 32'hAAAAAAAA;
        exp_last = 1; exp_cnt = 0; rsp_v = 0; rsp_own = 0; rsp_d = '0;

        // Reset with both masters requesting, then contention from release
        m0_valid = 1; m0_we = 0; m0_addr = 32'h40;
        m1_valid = 1; m1_we = 0; m1_addr = 32'h44;
        step(); step();
        rst = 1;
        repeat (4) step();
        check("cnt_after_4", 64'(conflict_cnt), 64'd4);
        m0_valid = 0; m1_valid = 0;
        step();

        // Single master read of word 4
        m0_valid = 1; m0_we = 0; m0_addr = 32'h10;
        step();
        m0_valid = 0;
        check("single_rd", 64'({m0_rvalid, m0_rdata}), 64'({1'b1, 32'hDEADBEEF}));
        check("single_rd_m1", 64'(m1_rvalid), 64'd0);
        step();

        // Partial write by m1 followed immediately by m0 read
        m1_valid = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678; m1_be = 4'b0011;
        step();
        m1_valid = 0; m0_valid = 1; m0_we = 0; m0_addr = 32'h20;
        step();
        m0_valid = 0;
        check("wr_then_rd", 64'({m0_rvalid, m0_rdata}), 64'({1'b1, 32'hAAAA5678}));
        step();

        // Reset asserted while m1 read is outstanding
        m1_valid = 1; m1_we = 0; m1_addr = 32'h30;
        step();
        m1_valid = 0;
        rst = 0;
        #1;
        check("rst_drop_rvalid", 64'({m1_rvalid, m1_rdata, ram_en, ram_we}), 64'd0);
        step();
        rst = 1;
        step();
        check("rst_no_rvalid", 64'({m1_rvalid, m0_rvalid}), 64'd0);
        check("rst_cnt", 64'(conflict_cnt), 64'd0);

        // Random traffic; requests held until accepted
        for (int c = 0; c < 3000; c++) begin
            step();
            if (m0_valid && winner == 0) m0_valid = 0;
            if (m1_valid && winner == 1) m1_valid = 0;
            if (!m0_valid && $urandom_range(0, 9) < 6)
                rand_req(m0_valid, m0_we, m0_addr, m0_wdata, m0_be);
            if (!m1_valid && $urandom_range(0, 9) < 6)
                rand_req(m1_valid, m1_we, m1_addr, m1_wdata, m1_be);
        end

        // Saturation under continuous contention
        rst = 0;
        step();
        rst = 1;
        m0_valid = 1; m0_we = 0; m0_addr = 32'h8;
        m1_valid = 1; m1_we = 0; m1_addr = 32'hC;
        for (int c = 0; c < 70000; c++) step();
        check("cnt_saturated", 64'(conflict_cnt), 64'hFFFF);
        m0_valid = 0; m1_valid = 0;
        step();
        check("cnt_no_wrap", 64'(conflict_cnt), 64'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
